mod_147_5: RTL

MOD_147_5 -- requirements
Module: mod_147_5

---
 rtl/mod_147_5.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mod_147_5.sv
// 100BASE-T1S-style PCS receive decoder: 5B symbol stream -> MII nibbles.
// Tracks SYNC/SSD framing, delays data two strobes, flags errors on RX_ER.
//
// Ports:
//   clk             PCS clock, rising edge
//   pcs_reset       synchronous active-high reset
//   link_control    0 = ENABLE, 1 = DISABLE (acts as reset)
//   rx_sym[4:0]     received 5B symbol, valid when rx_std = 1
//   rx_std          one-clock symbol strobe
//   RXDn[3:0]       decoded nibble (0000 when RX_DV = 0, except false carrier)
//   RX_DV           receive data valid
//   RX_ER           receive error
//   mod_147_5_state current state encoding
module mod_147_5 (
   input  logic       clk,
   input  logic       pcs_reset,
   input  logic       link_control,
   input  logic [4:0] rx_sym,
   input  logic       rx_std,
   output logic [3:0] RXDn,
   output logic       RX_DV,
   output logic       RX_ER,
   output logic [3:0] mod_147_5_state
);

   localparam logic [4:0] SYM_SYNC    = 5'b11000;
   localparam logic [4:0] SYM_SSD     = 5'b10001;
   localparam logic [4:0] SYM_ESD     = 5'b01101;
   localparam logic [4:0] SYM_ESDOK   = 5'b00111;
   localparam logic [4:0] SYM_SILENCE = 5'b00000;

   typedef enum logic [3:0] {
      WAIT_SYNC = 4'd0,
      SYNCING   = 4'd1,
      WAIT_SSD  = 4'd2,
      SSD2      = 4'd3,
      DATA      = 4'd4,
      ESD_WAIT  = 4'd5,
      BAD_SSD   = 4'd6
   } state_e;

   typedef struct packed {
      logic [3:0] nib;
      logic       vld;
      logic       err;
   } pent_t;

   localparam pent_t PENT_EMPTY = '{nib: 4'h0, vld: 1'b0, err: 1'b0};

   state_e     state_q, state_d;
   pent_t      p0_q, p0_d;
   pent_t      p1_q, p1_d;
   logic [3:0] rxd_q, rxd_d;
   logic       dv_q, dv_d;
   logic       er_q, er_d;

   logic [3:0] dec_nib;
   logic       dec_ok;
   pent_t      new_ent;

   always_comb begin
      dec_nib = 4'h0;
      dec_ok  = 1'b1;
      case (rx_sym)
         5'b11110: dec_nib = 4'h0;
         5'b01001: dec_nib = 4'h1;
         5'b10100: dec_nib = 4'h2;
         5'b10101: dec_nib = 4'h3;
         5'b01010: dec_nib = 4'h4;
         5'b01011: dec_nib = 4'h5;
         5'b01110: dec_nib = 4'h6;
         5'b01111: dec_nib = 4'h7;
         5'b10010: dec_nib = 4'h8;
         5'b10011: dec_nib = 4'h9;
         5'b10110: dec_nib = 4'hA;
         5'b10111: dec_nib = 4'hB;
         5'b11010: dec_nib = 4'hC;
         5'b11011: dec_nib = 4'hD;
         5'b11100: dec_nib = 4'hE;
         5'b11101: dec_nib = 4'hF;
         default:  dec_ok  = 1'b0;
      endcase
   end

   // Invalid codes still occupy a nibble slot, as 0000 tagged with err.
   always_comb begin
      new_ent     = PENT_EMPTY;
      new_ent.nib = dec_ok ? dec_nib : 4'h0;
      new_ent.vld = 1'b1;
      new_ent.err = ~dec_ok;
   end

   always_comb begin
      state_d = state_q;
      p0_d    = p0_q;
      p1_d    = p1_q;
      rxd_d   = rxd_q;
      dv_d    = dv_q;
      er_d    = er_q;
      if (rx_std) begin
         rxd_d = 4'h0;
         dv_d  = 1'b0;
         er_d  = 1'b0;
         unique case (state_q)
            WAIT_SYNC: begin
               if (rx_sym == SYM_SYNC) state_d = SYNCING;
            end
            SYNCING: begin
               state_d = (rx_sym == SYM_SYNC) ? WAIT_SSD : WAIT_SYNC;
            end
            WAIT_SSD: begin
               if (rx_sym == SYM_SSD) begin
                  state_d = SSD2;
               end else if (rx_sym != SYM_SYNC) begin
                  state_d = BAD_SSD;
                  er_d    = 1'b1;
                  rxd_d   = 4'hE;
               end
            end
            SSD2: begin
               if (rx_sym == SYM_SSD) begin
                  state_d = DATA;
               end else begin
                  state_d = BAD_SSD;
                  er_d    = 1'b1;
                  rxd_d   = 4'hE;
               end
            end
            DATA: begin
               if (rx_sym == SYM_SILENCE) begin
                  // Abort: the oldest nibble leaves flagged, the rest is dropped.
                  dv_d    = p1_q.vld;
                  er_d    = p1_q.vld;
                  rxd_d   = p1_q.vld ? p1_q.nib : 4'h0;
                  p0_d    = PENT_EMPTY;
                  p1_d    = PENT_EMPTY;
                  state_d = WAIT_SYNC;
               end else begin
                  dv_d  = p1_q.vld;
                  er_d  = p1_q.err;
                  rxd_d = p1_q.vld ? p1_q.nib : 4'h0;
                  p1_d  = p0_q;
                  if (rx_sym == SYM_ESD) begin
                     p0_d    = PENT_EMPTY;
                     state_d = ESD_WAIT;
                  end else begin
                     p0_d = new_ent;
                  end
               end
            end
            ESD_WAIT: begin
               // Last nibble carries the ESD status; empty frames stay silent.
               dv_d    = p1_q.vld;
               er_d    = p1_q.vld & (p1_q.err | (rx_sym != SYM_ESDOK));
               rxd_d   = p1_q.vld ? p1_q.nib : 4'h0;
               p0_d    = PENT_EMPTY;
               p1_d    = PENT_EMPTY;
               state_d = WAIT_SYNC;
            end
            BAD_SSD: begin
               state_d = WAIT_SYNC;
            end
            default: begin
               state_d = WAIT_SYNC;
               p0_d    = PENT_EMPTY;
               p1_d    = PENT_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (pcs_reset || link_control) begin
         state_q <= WAIT_SYNC;
         p0_q    <= PENT_EMPTY;
         p1_q    <= PENT_EMPTY;
         rxd_q   <= 4'h0;
         dv_q    <= 1'b0;
         er_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         p0_q    <= p0_d;
         p1_q    <= p1_d;
         rxd_q   <= rxd_d;
         dv_q    <= dv_d;
         er_q    <= er_d;
      end
   end

   assign RXDn            = rxd_q;
   assign RX_DV           = dv_q;
   assign RX_ER           = er_q;
   assign mod_147_5_state = state_q;

endmodule
